// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the register-file writeback trace buffer.
package wb_trace_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_CYC_W = 16;
  localparam int DROP_W    = 8;

  // `reg` is a reserved word, so the destination-register field is named wreg.
  typedef struct packed {
    logic [4:0]           wreg;
    logic [31:0]          data;
    logic [DEF_CYC_W-1:0] cycle;
  } wb_entry_t;

endpackage

// File: rtl/wb_sync_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count and synchronous flush.
module wb_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push.
  assign do_push = push && (!full || do_pop);
  assign count   = count_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !clear) mem[wr_ptr_reg] <= wdata;
  end

  // Head is read asynchronously so it falls through one cycle after the push.
  assign rdata = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures processor regfile writebacks with a cycle timestamp into a drainable FIFO,
// tracks dropped entries, and flags quiescence after a run of writeback-free cycles.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int CYC_W       = DEF_CYC_W,
  parameter int IDLE_CYCLES = 64,
  parameter int FILTER_R0   = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_clear,
  input  logic                   i_enable,
  input  logic                   i_ctrl_writeEnable,
  input  logic [4:0]             i_ctrl_writeReg,
  input  logic [31:0]            i_data_writeReg,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [4:0]             o_entry_reg,
  output logic [31:0]            o_entry_data,
  output logic [CYC_W-1:0]       o_entry_cycle,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_overflow,
  output logic [DROP_W-1:0]      o_drop_count,
  output logic                   o_idle_done
);

  localparam int ENTRY_W = 5 + 32 + CYC_W;
  localparam int IDLE_W  = $clog2(IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

  logic               push;
  logic               drop;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] head;
  logic [CYC_W-1:0]   cycle_reg;
  logic [IDLE_W-1:0]  idle_reg;
  logic               overflow_reg;
  logic [DROP_W-1:0]  drop_reg;

  assign push = i_enable && i_ctrl_writeEnable && !(FILTER_R0 != 0 && i_ctrl_writeReg == 5'd0);
  // While full, o_valid is high, so a ready consumer frees a slot this cycle.
  assign drop = push && full && !i_ready && !i_clear;

  wb_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (i_clear),
    .push  (push),
    .pop   (i_ready),
    .wdata ({i_ctrl_writeReg, i_data_writeReg, cycle_reg}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (o_count)
  );

  assign o_valid = !empty;
  assign o_full  = full;
  assign {o_entry_reg, o_entry_data, o_entry_cycle} = head;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycle_reg <= '0;
    else        cycle_reg <= cycle_reg + CYC_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_reg <= 1'b0;
      drop_reg     <= '0;
      idle_reg     <= '0;
    end else if (i_clear) begin
      overflow_reg <= 1'b0;
      drop_reg     <= '0;
      idle_reg     <= '0;
    end else begin
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_reg != '1) drop_reg <= drop_reg + DROP_W'(1);
      end
      // Any writeback counts as activity, even filtered or disabled ones.
      if (i_ctrl_writeEnable)     idle_reg <= '0;
      else if (idle_reg != IDLE_MAX) idle_reg <= idle_reg + IDLE_W'(1);
    end
  end

  assign o_overflow   = overflow_reg;
  assign o_drop_count = drop_reg;
  assign o_idle_done  = (idle_reg == IDLE_MAX);

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: expected entries are queued as writes are driven
// and compared in order as the FIFO is drained.
module tb_wb_trace_buffer;
  import wb_trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int CYC_W = 16;
  localparam int IDLE  = 64;

  logic        clock;
  logic        reset;
  logic        i_clear;
  logic        i_enable;
  logic        i_ctrl_writeEnable;
  logic [4:0]  i_ctrl_writeReg;
  logic [31:0] i_data_writeReg;
  logic        i_ready;
  logic        o_valid;
  logic [4:0]  o_entry_reg;
  logic [31:0] o_entry_data;
  logic [CYC_W-1:0] o_entry_cycle;
  logic [4:0]  o_count;
  logic        o_full;
  logic        o_overflow;
  logic [7:0]  o_drop_count;
  logic        o_idle_done;

  wb_trace_buffer #(
    .DEPTH(DEPTH), .CYC_W(CYC_W), .IDLE_CYCLES(IDLE), .FILTER_R0(1)
  ) dut (
    .clock(clock), .reset(reset), .i_clear(i_clear), .i_enable(i_enable),
    .i_ctrl_writeEnable(i_ctrl_writeEnable), .i_ctrl_writeReg(i_ctrl_writeReg),
    .i_data_writeReg(i_data_writeReg), .o_valid(o_valid), .i_ready(i_ready),
    .o_entry_reg(o_entry_reg), .o_entry_data(o_entry_data), .o_entry_cycle(o_entry_cycle),
    .o_count(o_count), .o_full(o_full), .o_overflow(o_overflow),
    .o_drop_count(o_drop_count), .o_idle_done(o_idle_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  wb_entry_t        exp_q[$];
  int               n_checks = 0;
  int               n_fail = 0;
  logic [CYC_W-1:0] tb_cyc;

  // Reference timestamp counter.
  always @(posedge clock or negedge reset) begin
    if (!reset) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 1'b1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d, input bit keep);
    i_ctrl_writeEnable = 1'b1;
    i_ctrl_writeReg    = r;
    i_data_writeReg    = d;
    if (keep) exp_q.push_back('{wreg: r, data: d, cycle: tb_cyc});
    $display("write r%0d=%08h keep=%0d cyc=%0d", r, d, keep, tb_cyc);
    tick();
    i_ctrl_writeEnable = 1'b0;
  endtask

  task automatic drain(input string tag);
    wb_entry_t e;
    i_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q[0];
      n_checks++;
      if (o_valid !== 1'b1 || o_entry_reg !== e.wreg || o_entry_data !== e.data ||
          o_entry_cycle !== e.cycle) begin
        $display("FAIL %s_head: got v=%0b r%0d %08h cyc=%0d, expected v=1 r%0d %08h cyc=%0d",
                 tag, o_valid, o_entry_reg, o_entry_data, o_entry_cycle, e.wreg, e.data, e.cycle);
        n_fail++;
      end else begin
        $display("pop  r%0d=%08h cyc=%0d", o_entry_reg, o_entry_data, o_entry_cycle);
      end
      tick();
      void'(exp_q.pop_front());
    end
    i_ready = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_count !== 5'd0) begin
      $display("FAIL %s_empty: got valid=%0b count=%0d, expected 0 0", tag, o_valid, o_count);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; i_clear = 1'b0; i_enable = 1'b1; i_ready = 1'b0;
    i_ctrl_writeEnable = 1'b0; i_ctrl_writeReg = '0; i_data_writeReg = '0;
    repeat (3) tick();
    n_checks++;
    if ({o_valid, o_count, o_full, o_overflow, o_drop_count, o_idle_done} !== '0) begin
      $display("FAIL reset_status: got v=%0b cnt=%0d full=%0b ovf=%0b drop=%0d idle=%0b, expected all 0",
               o_valid, o_count, o_full, o_overflow, o_drop_count, o_idle_done);
      n_fail++;
    end
    n_checks++;
    if ({o_entry_reg, o_entry_data, o_entry_cycle} !== '0) begin
      $display("FAIL reset_entry: got r%0d %08h cyc=%0d, expected 0", o_entry_reg, o_entry_data, o_entry_cycle);
      n_fail++;
    end
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic test_in_order();
    i_ready = 1'b0;
    for (int k = 0; k < 20 && tb_cyc < 10; k++) tick();
    wr(5'd1, 32'd65535, 1'b1);
    wr(5'd2, 32'd5, 1'b1);
    wr(5'd3, 32'hDEADBEEF, 1'b1);
    n_checks++;
    if (o_count !== 5'd3) begin
      $display("FAIL order_count: got %0d, expected 3", o_count);
      n_fail++;
    end
    n_checks++;
    if (o_entry_cycle !== 16'd10) begin
      $display("FAIL order_first_ts: got %0d, expected 10", o_entry_cycle);
      n_fail++;
    end
    drain("order");
  endtask

  task automatic test_filter_idle();
    repeat (IDLE) tick();
    n_checks++;
    if (o_idle_done !== 1'b1) begin
      $display("FAIL idle_before_r0: got %0b, expected 1", o_idle_done);
      n_fail++;
    end
    wr(5'd0, 32'h1234, 1'b0);
    n_checks++;
    if (o_count !== 5'd0 || o_valid !== 1'b0 || o_idle_done !== 1'b0) begin
      $display("FAIL filter_r0: got cnt=%0d valid=%0b idle=%0b, expected 0 0 0", o_count, o_valid, o_idle_done);
      n_fail++;
    end
    repeat (IDLE - 1) tick();
    n_checks++;
    if (o_idle_done !== 1'b0) begin
      $display("FAIL idle_early: got %0b at %0d cycles, expected 0", o_idle_done, IDLE - 1);
      n_fail++;
    end
    tick();
    n_checks++;
    if (o_idle_done !== 1'b1) begin
      $display("FAIL idle_at_limit: got %0b at %0d cycles, expected 1", o_idle_done, IDLE);
      n_fail++;
    end
    i_enable = 1'b0;
    wr(5'd5, 32'h55, 1'b0);
    i_enable = 1'b1;
    n_checks++;
    if (o_count !== 5'd0 || o_idle_done !== 1'b0) begin
      $display("FAIL disabled_write: got cnt=%0d idle=%0b, expected 0 0", o_count, o_idle_done);
      n_fail++;
    end
  endtask

  task automatic test_overflow_clear();
    i_ready = 1'b0;
    for (int k = 0; k < DEPTH + 2; k++)
      wr(5'(k + 1), 32'hA000 + k, exp_q.size() < DEPTH);
    n_checks++;
    if (o_full !== 1'b1 || o_overflow !== 1'b1 || o_drop_count !== 8'd2 || o_count !== 5'd16) begin
      $display("FAIL overflow: got full=%0b ovf=%0b drop=%0d cnt=%0d, expected 1 1 2 16",
               o_full, o_overflow, o_drop_count, o_count);
      n_fail++;
    end
    n_checks++;
    if (o_entry_data !== 32'hA000) begin
      $display("FAIL overflow_head: got %08h, expected 0000a000", o_entry_data);
      n_fail++;
    end
    i_clear = 1'b1;
    wr(5'd4, 32'hC1EA, 1'b0);
    i_clear = 1'b0;
    exp_q.delete();
    n_checks++;
    if (o_count !== 5'd0 || o_valid !== 1'b0 || o_overflow !== 1'b0 || o_drop_count !== 8'd0 || o_full !== 1'b0) begin
      $display("FAIL clear: got cnt=%0d valid=%0b ovf=%0b drop=%0d full=%0b, expected all 0",
               o_count, o_valid, o_overflow, o_drop_count, o_full);
      n_fail++;
    end
  endtask

  task automatic test_full_push_pop();
    i_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) wr(5'(k + 1), 32'hB000 + k, 1'b1);
    n_checks++;
    if (o_full !== 1'b1 || o_count !== 5'd16) begin
      $display("FAIL fill: got full=%0b cnt=%0d, expected 1 16", o_full, o_count);
      n_fail++;
    end
    i_ready = 1'b1;
    wr(5'd20, 32'hFEED, 1'b1);
    void'(exp_q.pop_front());
    i_ready = 1'b0;
    n_checks++;
    if (o_count !== 5'd16 || o_overflow !== 1'b0 || o_drop_count !== 8'd0 || o_entry_data !== 32'hB001) begin
      $display("FAIL full_push_pop: got cnt=%0d ovf=%0b drop=%0d head=%08h, expected 16 0 0 0000b001",
               o_count, o_overflow, o_drop_count, o_entry_data);
      n_fail++;
    end
    drain("full_pp");
  endtask

  task automatic test_reset_mid_drain();
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) wr(5'(k + 10), 32'hD000 + k, 1'b1);
    i_ready = 1'b1;
    tick();
    void'(exp_q.pop_front());
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_count !== 5'd0) begin
      $display("FAIL async_reset: got valid=%0b cnt=%0d, expected 0 0", o_valid, o_count);
      n_fail++;
    end
    exp_q.delete();
    i_ready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    wr(5'd7, 32'h7777, 1'b1);
    n_checks++;
    if (o_valid !== 1'b1 || o_entry_cycle !== 16'd0) begin
      $display("FAIL ts_restart: got valid=%0b cyc=%0d, expected 1 0", o_valid, o_entry_cycle);
      n_fail++;
    end
    drain("post_reset");
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_filter_idle();
    test_overflow_clear();
    test_full_push_pop();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
Sits directly downstream of the processor's register-file writeback port (ctrl_writeEnable / ctrl_writeReg / data_writeReg).
- Captures every qualifying writeback into an on-chip FIFO, with a free-running cycle timestamp.
- A checker or bench drains the FIFO through a valid/ready port, so it can compare the instruction stream's effects in order instead of only inspecting final register contents.
- Also flags program quiescence: no writebacks for a programmable number of cycles.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
CYC_W, 16, timestamp width in bits; the counter wraps modulo 2^CYC_W.
IDLE_CYCLES, 64, count of consecutive cycles with no writeback before o_idle_done asserts.
FILTER_R0, 1, when 1, writes to r0 are not captured.

Ports:
clock  in  1  single system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
i_clear  in  1  synchronous flush; see Behaviour.
i_enable  in  1  capture enable.
i_ctrl_writeEnable  in  1  regfile write strobe from the processor.
i_ctrl_writeReg  in  5  destination register.
i_data_writeReg  in  32  write data.
o_valid  out  1  head entry available.
i_ready  in  1  consumer accepts the head entry.
o_entry_reg  out  5  head entry: destination register.
o_entry_data  out  32  head entry: data.
o_entry_cycle  out  CYC_W  head entry: timestamp.
o_count  out  $clog2(DEPTH)+1  current number of entries.
o_full  out  1  o_count == DEPTH.
o_overflow  out  1  sticky; set when an entry has been dropped.
o_drop_count  out  8  number of dropped entries; saturates at 255.
o_idle_done  out  1  quiescence flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - All state is zero: FIFO empty, o_valid=0, o_count=0, o_full=0, o_overflow=0, o_drop_count=0, o_idle_done=0, cycle counter=0, idle counter=0.
  - Entry outputs read 0 while the FIFO is empty.
  - Reset asserted mid-drain discards all content immediately.
- Cycle counter:
  - Increments on every rising edge after reset; wraps from 2^CYC_W-1 to 0.
  - An entry's timestamp is the counter value in the capture cycle, sampled before that edge's increment.
- Capture qualifier ("push"): i_enable && i_ctrl_writeEnable && !(FILTER_R0 && i_ctrl_writeReg==0).
- FIFO, first-word-fall-through:
  - o_valid = !empty.
  - Head fields are driven combinationally from the read pointer.
  - Pop occurs on valid && ready.
  - Latency: an entry pushed at edge N is visible on the outputs after edge N, i.e. 1 cycle.
- Boundary cases:
  - Empty, push and ready=1 together: the push is stored. There is no same-cycle bypass pop, because o_valid was 0.
  - Full, push and pop together: both succeed; o_count stays DEPTH.
  - Full, push without pop: the entry is dropped. o_overflow is set and stays set; o_drop_count increments, saturating at 255.
  - Pop while empty: ignored.
  - Pointers wrap modulo DEPTH.
- Idle counter:
  - Resets to 0 on any cycle with i_ctrl_writeEnable=1. This applies regardless of filter or enable.
  - Otherwise increments, saturating at IDLE_CYCLES.
  - o_idle_done is registered and equals (idle counter == IDLE_CYCLES).
  - It deasserts on the edge after a writeback arrives.
- i_clear:
  - Flushes the FIFO and zeroes o_overflow, o_drop_count and the idle counter. The cycle counter is not cleared.
  - A push in the same cycle as i_clear is discarded; clear wins.
- No combinational path from i_ready to o_valid.

Decomposition:
- Shared package wb_trace_pkg holds:
  - the wb_entry_t typedef {reg[4:0], data[31:0], cycle[CYC_W-1:0]};
  - the DEPTH and CYC_W defaults;
  - the DROP_W=8 constant.
- One sub-module: wb_sync_fifo. It is a generic FWFT FIFO with push, pop, clear, full, empty and count.
- The top level contains the qualifier, the timestamp counter, the overflow/drop logic and the idle logic.

Test Plan:
- Reset, then 3 writes (r1=65535, r2=5, r3=0xDEADBEEF) at cycles 10, 11, 12 with i_ready=0 -> o_count=3. Drain with i_ready=1 -> entries come out in that order with timestamps 10, 11, 12, then o_valid=0.
- Write to r0 with FILTER_R0=1 -> no entry and o_count unchanged. The same write with i_enable=0 -> no entry, but the idle counter still resets.
- 18 writes into DEPTH=16 with i_ready=0 -> o_full=1, o_overflow=1, o_drop_count=2; the FIFO holds the first 16 entries. Then pulse i_clear -> o_count=0, o_overflow=0, o_drop_count=0.
- While full, push and pop in the same cycle -> o_count stays 16, the head advances, and the new entry appears last.
- No writes for 64 cycles -> o_idle_done=1 at cycle 64 after the last write. One more write -> o_idle_done=0 on the next edge.
- Pull reset low mid-drain with 5 entries queued -> o_valid=0 and o_count=0 asynchronously. After release, the timestamp restarts at 0.
